modmul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `ModuloProduct` engine among N_REQ requesters, such as the point-add, point-double and inversion units. It accepts one modular-multiply request at a time and latches that requester's operands. It then drives the engine's start/finished handshake and returns the product to the granted requester with a one-cycle done pulse. The block sits between the ECC point-arithmetic units and the single multiplier instance.

---
 rtl/modmul_arbiter.sv | 113 +++++++++++
 tb/tb_modmul_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one ModuloProduct engine among N_REQ requesters.
// Latches the winner's operands, sequences start/finished, returns product with o_done.
`ifndef MAX_BITS
`define MAX_BITS 256
`endif
`ifndef BITS32
`define BITS32  2'd0
`define BITS64  2'd1
`define BITS128 2'd2
`define BITS256 2'd3
`endif

module modmul_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*`MAX_BITS-1:0]  i_a,
    input  logic [N_REQ*`MAX_BITS-1:0]  i_b,
    input  logic [`MAX_BITS-1:0]        i_n,
    input  logic [1:0]                  i_mode,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_done,
    output logic [`MAX_BITS-1:0]        o_result,
    output logic                        o_busy,
    output logic                        o_mm_start,
    output logic [`MAX_BITS-1:0]        o_mm_a,
    output logic [`MAX_BITS-1:0]        o_mm_b,
    output logic [`MAX_BITS-1:0]        o_mm_n,
    output logic [1:0]                  o_mm_mode,
    input  logic [`MAX_BITS-1:0]        i_mm_result,
    input  logic                        i_mm_finished
);

    localparam int MB = `MAX_BITS;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] win;
    logic             win_vld;
    int               k;

    // Search starts just past the last served requester and wraps.
    always_comb begin
        win     = last;
        win_vld = 1'b0;
        k       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last) + i) % N_REQ;
            if (!win_vld && i_req[k]) begin
                win_vld = 1'b1;
                win     = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (win_vld) state_nx = START;
            START: state_nx = WAIT;
            WAIT:  if (i_mm_finished) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last      <= IDX_W'(N_REQ - 1);
            gnt_idx   <= '0;
            o_gnt     <= '0;
            o_result  <= '0;
            o_mm_a    <= '0;
            o_mm_b    <= '0;
            o_mm_n    <= '0;
            o_mm_mode <= `BITS32;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    gnt_idx   <= win;
                    o_gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    o_mm_a    <= i_a[int'(win)*MB +: MB];
                    o_mm_b    <= i_b[int'(win)*MB +: MB];
                    o_mm_n    <= i_n;
                    o_mm_mode <= i_mode;
                end
                WAIT: if (i_mm_finished) begin
                    o_result <= i_mm_result;
                    last     <= gnt_idx;
                end
                DONE: o_gnt <= '0;
                default: ;
            endcase
        end
    end

    // Grant stays one-hot through DONE, so it doubles as the done vector.
    assign o_done     = (state == DONE) ? o_gnt : '0;
    assign o_busy     = (state != IDLE);
    assign o_mm_start = (state == START);

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a small fixed-latency engine model.
// Checks grant order, operand latching, done pulses and reset behaviour.
module tb_modmul_arbiter;

    localparam int N  = 4;
    localparam int MB = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*MB-1:0]   a = '0;
    logic [N*MB-1:0]   b = '0;
    logic [MB-1:0]     n = '0;
    logic [1:0]        mode = 2'd0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [MB-1:0]     result;
    logic              busy;
    logic              mm_start;
    logic [MB-1:0]     mm_a;
    logic [MB-1:0]     mm_b;
    logic [MB-1:0]     mm_n;
    logic [1:0]        mm_mode;
    logic [MB-1:0]     mm_result;
    logic              fin;
    logic              spur = 1'b0;
    logic              mm_fin;
    logic [2:0]        cnt;
    logic [MB-1:0]     p25519;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mm_fin = fin | spur;

    modmul_arbiter #(.N_REQ(N), .IDX_W(2)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_req(req),
        .i_a(a), .i_b(b), .i_n(n), .i_mode(mode),
        .o_gnt(gnt), .o_done(done), .o_result(result), .o_busy(busy),
        .o_mm_start(mm_start), .o_mm_a(mm_a), .o_mm_b(mm_b),
        .o_mm_n(mm_n), .o_mm_mode(mm_mode),
        .i_mm_result(mm_result), .i_mm_finished(mm_fin)
    );

    // Engine stand-in: three cycles after start, reads operands and pulses finished.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fin       <= 1'b0;
            mm_result <= '0;
        end else begin
            fin <= 1'b0;
            if (mm_start) cnt <= 3'd3;
            else if (cnt != 0) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) begin
                    fin       <= 1'b1;
                    mm_result <= 256'(({256'b0, mm_a} * {256'b0, mm_b})
                                      % {256'b0, mm_n});
                end
            end
        end
    end

    task automatic check(input string tag, input logic [MB-1:0] got,
                         input logic [MB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag);
        int t = 0;
        while (gnt == '0 && t < 20) begin
            tick();
            t++;
        end
        check({tag, "_gnt_seen"}, MB'(gnt != '0), 256'd1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done == '0 && t < 20) begin
            tick();
            t++;
        end
        check({tag, "_done_seen"}, MB'(done != '0), 256'd1);
    endtask

    initial begin
        int ord [5] = '{0, 1, 2, 3, 0};
        int exp [5] = '{10, 20, 30, 40, 10};
        p25519 = (256'd1 << 255) - 256'd19;

        // Reset state
        tick();
        tick();
        check("rst_gnt",   MB'(gnt), 0);
        check("rst_done",  MB'(done), 0);
        check("rst_busy",  MB'(busy), 0);
        check("rst_start", MB'(mm_start), 0);
        check("rst_res",   result, 0);
        check("rst_mode",  MB'(mm_mode), 0);
        rst_n = 1'b1;
        tick();

        // Single request on requester 2, BITS32
        n = 256'd97;
        a[2*MB +: MB] = 256'd5;
        b[2*MB +: MB] = 256'd7;
        req = 4'b0100;
        tick();
        check("s_gnt",   MB'(gnt), 256'b0100);
        check("s_start", MB'(mm_start), 1);
        check("s_mm_a",  mm_a, 256'd5);
        tick();
        check("s_start_off", MB'(mm_start), 0);
        wait_done("s");
        check("s_done", MB'(done), 256'b0100);
        check("s_res",  result, 256'd35);
        req = '0;
        tick();
        check("s_gnt_clr", MB'(gnt), 0);
        check("s_idle",    MB'(busy), 0);

        // Modular wrap, BITS32
        a[0 +: MB] = 256'd50;
        b[0 +: MB] = 256'd3;
        req = 4'b0001;
        wait_gnt("w");
        check("w_gnt", MB'(gnt), 256'b0001);
        wait_done("w");
        check("w_res", result, 256'd53);
        req = '0;
        tick();

        // BITS256 wrap with n = 2^255-19
        n    = p25519;
        mode = 2'd3;
        a[MB +: MB] = 256'd2;
        b[MB +: MB] = p25519 - 256'd1;
        req = 4'b0010;
        wait_gnt("w256");
        check("w256_mode", MB'(mm_mode), 256'd3);
        wait_done("w256");
        check("w256_res", result, p25519 - 256'd2);
        req = '0;
        tick();

        // All four requesting continuously from reset
        rst_n = 1'b0;
        n    = 256'd97;
        mode = 2'd0;
        for (int k = 0; k < N; k++) begin
            a[k*MB +: MB] = MB'(k + 1);
            b[k*MB +: MB] = 256'd10;
        end
        req = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_gnt("rr");
            check($sformatf("rr%0d_gnt", j), MB'(gnt), MB'(1) << ord[j]);
            wait_done("rr");
            check($sformatf("rr%0d_res", j), result, MB'(exp[j]));
            if (j == 4) req = '0;
            tick();
        end

        // Operand change and new request during WAIT of requester 0
        a[0 +: MB] = 256'd4;
        b[0 +: MB] = 256'd6;
        req = 4'b0001;
        wait_gnt("mid");
        check("mid_gnt0", MB'(gnt), 256'b0001);
        tick();
        a[0 +: MB] = 256'd9;
        req = 4'b0011;
        tick();
        check("mid_gnt_hold", MB'(gnt), 256'b0001);
        wait_done("mid");
        check("mid_done", MB'(done), 256'b0001);
        check("mid_res",  result, 256'd24);
        req = 4'b0010;
        tick();
        check("mid_gap", MB'(gnt), 0);
        tick();
        check("mid_gnt1", MB'(gnt), 256'b0010);
        wait_done("mid1");
        check("mid1_res", result, 256'd20);
        req = '0;
        tick();

        // Requester 3 drops its request after grant
        req = 4'b1000;
        wait_gnt("drop");
        check("drop_gnt", MB'(gnt), 256'b1000);
        tick();
        req = '0;
        wait_done("drop");
        check("drop_done", MB'(done), 256'b1000);
        check("drop_res",  result, 256'd40);
        repeat (3) tick();
        check("drop_nognt", MB'(gnt), 0);
        check("drop_idle",  MB'(busy), 0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_done", MB'(done), 0);
        check("spur_busy", MB'(busy), 0);
        check("spur_res",  result, 256'd40);

        // Reset in WAIT; priority must return to requester 0
        req = 4'b0010;
        wait_gnt("pre");
        wait_done("pre");
        req = '0;
        tick();
        a[2*MB +: MB] = 256'd3;
        req = 4'b0100;
        wait_gnt("rw");
        check("rw_gnt", MB'(gnt), 256'b0100);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rw_gnt_clr", MB'(gnt), 0);
        check("rw_busy",    MB'(busy), 0);
        check("rw_done",    MB'(done), 0);
        check("rw_mm_a",    mm_a, 0);
        check("rw_res",     result, 0);
        a[0 +: MB] = 256'd1;
        b[0 +: MB] = 256'd10;
        req = 4'b1111;
        tick();
        check("rw_done2", MB'(done), 0);
        rst_n = 1'b1;
        tick();
        check("rw_prio", MB'(gnt), 256'b0001);
        wait_done("rw0");
        check("rw0_res", result, 256'd10);
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
